weight_fetcher: RTL and testbench
=================================

WEIGHT_FETCHER -- requirements
Module: weight_fetcher

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 8, bits per weight.
REQ-002 SHALL have parameter NUM_KERNEL, default 4, kernels per memory word.
REQ-003 SHALL have parameter NUM_CHANNEL, default 3, channels per kernel word.
REQ-004 SHALL have parameter NUM_RDATA, default 3, positions (words) per group.
REQ-005 SHALL have parameter ADDR_WIDTH, default 16, weight memory address width.
REQ-006 SHALL have parameter GRP_WIDTH, default 16, group counter width.
REQ-007 SHALL have the following ports (W = DAT_WIDTH*NUM_CHANNEL):
- clk  in  1  clock; one clock domain; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; launches a job; sampled only in IDLE.
- i_base_addr  in  ADDR_WIDTH  first memory word of the job; latched on accepted start.
- i_num_groups  in  GRP_WIDTH  groups in the job; latched on accepted start.
- i_kn_mask  in  NUM_KERNEL  per-kernel enable; latched on accepted start.
- o_mem_en  out  1  weight memory read enable.
- o_mem_addr  out  ADDR_WIDTH  weight memory read address.
- i_mem_data  in  W*NUM_KERNEL  read data, valid exactly 1 cycle after o_mem_en; kernel k occupies bits [W*(k+1)-1 : W*k].
- o_data_kn0..o_data_kn3  out  W each  per-kernel weight word to the weight buffer.
- o_data_kn0_val..o_data_kn3_val  out  1 each  per-kernel word valid.
- i_data_req  in  1  consumer request; same signal that clears the weight buffer's valids.
- o_busy  out  1  high while not IDLE.
- o_done  out  1  one-cycle pulse at job end.
- o_err  out  1  sticky protocol-error flag.

Function
REQ-008 SHALL implement FSM states IDLE, FETCH, DRAIN, WAIT_REQ, DONE.
REQ-009 IDLE: i_start=1 -> latch inputs, clear group count; next state FETCH if i_num_groups != 0, else DONE.
REQ-010 FETCH: SHALL assert o_mem_en for exactly NUM_RDATA consecutive cycles, addresses base+NUM_RDATA*g+0, +1, +2 ascending (g = current group), then enter DRAIN.
REQ-011 Output words SHALL be registered: o_data_knK and o_data_knK_val update 2 cycles after the corresponding o_mem_en cycle; val = 1 only if i_kn_mask[K]=1.
REQ-012 Words SHALL be emitted in address order, so the word at offset 0 is the oldest in the consumer shift chain.
REQ-013 DRAIN: SHALL hold until the last word of the group has been emitted, then enter WAIT_REQ.
REQ-014 WAIT_REQ: i_data_req=1 -> increment g; if g+1 = num_groups go DONE, else FETCH (o_mem_en high the next cycle).
REQ-015 DONE: SHALL pulse o_done for one cycle and return to IDLE.
REQ-016 i_data_req=1 in FETCH or DRAIN SHALL set o_err (sticky until reset or next accepted i_start) and SHALL otherwise be ignored.
REQ-017 i_start when not IDLE SHALL be ignored.
REQ-018 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH with no error.
REQ-019 Group counter SHALL be GRP_WIDTH wide; i_num_groups = 2^GRP_WIDTH-1 SHALL complete without overflow.
REQ-020 o_data_knK SHALL hold its last value when val=0.

Reset
REQ-021 rst SHALL force IDLE and zero all outputs, counters and latched inputs on the next edge, including mid-job; data from reads in flight SHALL be discarded (no val).
REQ-022 rst SHALL have priority over i_start and i_data_req in the same cycle.

Structure
REQ-023 Parameters W, FSM state encoding and default widths SHALL live in a shared package (weight_pkg) used with the weight buffer.
REQ-024 The per-kernel output register plus mask SHALL be one sub-module, weight_fetch_outreg, instantiated NUM_KERNEL times via generate.

Verification
REQ-025 base=0x0010, groups=1, mask=4'b1111 -> o_mem_addr 0x10,0x11,0x12 on 3 consecutive cycles; all 4 vals high 3 cycles, lagging o_mem_en by 2; then WAIT_REQ; req -> o_done pulse.
REQ-026 groups=2, mask=4'b0101 -> only kn0, kn2 vals assert; second group addresses base+3..base+5 start the cycle after req.
REQ-027 groups=0 -> no o_mem_en, o_done 2 cycles after start.
REQ-028 req pulsed during FETCH -> o_err=1, sequence unaffected; o_err cleared by next start.
REQ-029 base=0xFFFE, groups=1 -> addresses 0xFFFE, 0xFFFF, 0x0000.
REQ-030 rst asserted on the 2nd FETCH cycle -> next cycle o_busy=0, no val asserted afterward; new start runs cleanly.

Source files
------------

// File: rtl/weight_pkg.sv
// Shared weight-path definitions: default widths, word size helper
// and the fetcher FSM encoding, also used by the weight buffer.
package weight_pkg;

    localparam int WF_DAT_WIDTH   = 8;
    localparam int WF_NUM_KERNEL  = 4;
    localparam int WF_NUM_CHANNEL = 3;
    localparam int WF_NUM_RDATA   = 3;
    localparam int WF_ADDR_WIDTH  = 16;
    localparam int WF_GRP_WIDTH   = 16;

    // Bits in one per-kernel word (all channels of one position)
    function automatic int wf_word_w(input int dat_w, input int n_ch);
        return dat_w * n_ch;
    endfunction

    localparam int WF_W = wf_word_w(WF_DAT_WIDTH, WF_NUM_CHANNEL);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_WAIT_REQ,
        ST_DONE
    } wf_state_e;

endpackage

// File: rtl/weight_fetch_outreg.sv
// Per-kernel output register: captures one kernel slice of a read
// word when the read is valid and the kernel is enabled.
module weight_fetch_outreg #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd_vld_i,
    input  logic         en_i,
    input  logic [W-1:0] rd_data_i,
    output logic [W-1:0] data_o,
    output logic         val_o
);

    logic         cap;
    logic [W-1:0] data_q;
    logic         val_q;

    assign cap = rd_vld_i & en_i;

    // Load on masked valid read; data holds otherwise, val is a pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            val_q  <= 1'b0;
        end else begin
            val_q <= cap;
            if (cap) begin
                data_q <= rd_data_i;
            end
        end
    end

    assign data_o = data_q;
    assign val_o  = val_q;

endmodule

// File: rtl/weight_fetcher.sv
// Weight fetcher: reads NUM_RDATA memory words per group and hands
// each kernel slice to the weight buffer, one group per consumer req.
module weight_fetcher
    import weight_pkg::*;
#(
    parameter int DAT_WIDTH   = WF_DAT_WIDTH,
    parameter int NUM_KERNEL  = WF_NUM_KERNEL,
    parameter int NUM_CHANNEL = WF_NUM_CHANNEL,
    parameter int NUM_RDATA   = WF_NUM_RDATA,
    parameter int ADDR_WIDTH  = WF_ADDR_WIDTH,
    parameter int GRP_WIDTH   = WF_GRP_WIDTH,
    localparam int W = DAT_WIDTH * NUM_CHANNEL
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [GRP_WIDTH-1:0]    i_num_groups,
    input  logic [NUM_KERNEL-1:0]   i_kn_mask,
    output logic                    o_mem_en,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    input  logic [W*NUM_KERNEL-1:0] i_mem_data,
    output logic [W-1:0]            o_data_kn0,
    output logic [W-1:0]            o_data_kn1,
    output logic [W-1:0]            o_data_kn2,
    output logic [W-1:0]            o_data_kn3,
    output logic                    o_data_kn0_val,
    output logic                    o_data_kn1_val,
    output logic                    o_data_kn2_val,
    output logic                    o_data_kn3_val,
    input  logic                    i_data_req,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);

    localparam int CW = (NUM_RDATA > 1) ? $clog2(NUM_RDATA) : 1;

    wf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [GRP_WIDTH-1:0]  ngrp_q, ngrp_d;
    logic [GRP_WIDTH-1:0]  grp_q, grp_d;
    logic [GRP_WIDTH-1:0]  grp_inc;
    logic [NUM_KERNEL-1:0] mask_q, mask_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  rd_vld_q;
    logic                  mem_en;

    assign grp_inc = grp_q + GRP_WIDTH'(1);

    // Next-state, fetch sequencing and error/done decode
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ngrp_d  = ngrp_q;
        grp_d   = grp_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        mem_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    addr_d  = i_base_addr;
                    ngrp_d  = i_num_groups;
                    mask_d  = i_kn_mask;
                    grp_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (i_num_groups != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                mem_en = 1'b1;
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (i_data_req) begin
                    err_d = 1'b1;
                end
                if (cnt_q == CW'(NUM_RDATA - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (i_data_req) begin
                    err_d = 1'b1;
                end
                if (rd_vld_q) begin
                    state_d = ST_WAIT_REQ;
                end
            end
            ST_WAIT_REQ: begin
                if (i_data_req) begin
                    grp_d   = grp_inc;
                    state_d = (grp_inc == ngrp_q) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched job parameters and read-valid pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            ngrp_q   <= '0;
            grp_q    <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            ngrp_q   <= ngrp_d;
            grp_q    <= grp_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            done_q   <= done_d;
            rd_vld_q <= mem_en;
        end
    end

    logic [W-1:0]          kn_data [NUM_KERNEL];
    logic [NUM_KERNEL-1:0] kn_val;

    for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_kn
        weight_fetch_outreg #(
            .W (W)
        ) u_outreg (
            .clk       (clk),
            .rst       (rst),
            .rd_vld_i  (rd_vld_q),
            .en_i      (mask_q[k]),
            .rd_data_i (i_mem_data[W*k +: W]),
            .data_o    (kn_data[k]),
            .val_o     (kn_val[k])
        );
    end

    assign o_mem_en       = mem_en;
    assign o_mem_addr     = addr_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_done         = done_q;
    assign o_err          = err_q;
    assign o_data_kn0     = kn_data[0];
    assign o_data_kn1     = kn_data[1];
    assign o_data_kn2     = kn_data[2];
    assign o_data_kn3     = kn_data[3];
    assign o_data_kn0_val = kn_val[0];
    assign o_data_kn1_val = kn_val[1];
    assign o_data_kn2_val = kn_val[2];
    assign o_data_kn3_val = kn_val[3];

endmodule

// File: tb/tb_weight_fetcher.sv
// Self-checking bench for weight_fetcher: directed jobs plus random
// jobs compared against an address/lag reference model.
module tb_weight_fetcher;

    localparam int W  = 24;
    localparam int NK = 4;
    localparam int AW = 16;
    localparam int GW = 16;
    localparam int NR = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_start = 1'b0;
    logic [AW-1:0]   i_base_addr = '0;
    logic [GW-1:0]   i_num_groups = '0;
    logic [NK-1:0]   i_kn_mask = '0;
    logic            o_mem_en;
    logic [AW-1:0]   o_mem_addr;
    logic [W*NK-1:0] i_mem_data = '0;
    logic [W-1:0]    o_data_kn0, o_data_kn1, o_data_kn2, o_data_kn3;
    logic            o_data_kn0_val, o_data_kn1_val;
    logic            o_data_kn2_val, o_data_kn3_val;
    logic            i_data_req = 1'b0;
    logic            o_busy, o_done, o_err;

    int checks = 0;
    int errors = 0;

    weight_fetcher dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_base_addr    (i_base_addr),
        .i_num_groups   (i_num_groups),
        .i_kn_mask      (i_kn_mask),
        .o_mem_en       (o_mem_en),
        .o_mem_addr     (o_mem_addr),
        .i_mem_data     (i_mem_data),
        .o_data_kn0     (o_data_kn0),
        .o_data_kn1     (o_data_kn1),
        .o_data_kn2     (o_data_kn2),
        .o_data_kn3     (o_data_kn3),
        .o_data_kn0_val (o_data_kn0_val),
        .o_data_kn1_val (o_data_kn1_val),
        .o_data_kn2_val (o_data_kn2_val),
        .o_data_kn3_val (o_data_kn3_val),
        .i_data_req     (i_data_req),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err)
    );

    always #5 clk = ~clk;

    logic [7:0] salt [NK];

    function automatic logic [W*NK-1:0] mem_word(input logic [AW-1:0] a);
        logic [W*NK-1:0] r;
        for (int k = 0; k < NK; k++) r[W*k +: W] = {salt[k], a};
        return r;
    endfunction

    // Weight memory: one-cycle read latency
    always @(posedge clk) begin
        if (o_mem_en) i_mem_data <= mem_word(o_mem_addr);
    end

    logic          hv [2];
    logic [AW-1:0] ha [2];
    logic [W-1:0]  exp_d [NK];
    logic [NK-1:0] cur_mask = '0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        hv[0] = 1'b0; hv[1] = 1'b0;
        ha[0] = '0;   ha[1] = '0;
        for (int k = 0; k < NK; k++) exp_d[k] = '0;
    endtask

    // One cycle of observation: read port and words emitted 2 cycles
    // after their read enable, masked per kernel, data held otherwise.
    task automatic sample(input bit en, input logic [AW-1:0] a);
        logic [NK-1:0]   ev;
        logic [W*NK-1:0] mw;
        chk("mem_en", o_mem_en, en);
        if (en) chk("mem_addr", o_mem_addr, a);
        ev = hv[1] ? cur_mask : '0;
        mw = mem_word(ha[1]);
        for (int k = 0; k < NK; k++) if (ev[k]) exp_d[k] = mw[W*k +: W];
        chk("vals", {o_data_kn3_val, o_data_kn2_val,
                     o_data_kn1_val, o_data_kn0_val}, ev);
        chk("kn0", o_data_kn0, exp_d[0]);
        chk("kn1", o_data_kn1, exp_d[1]);
        chk("kn2", o_data_kn2, exp_d[2]);
        chk("kn3", o_data_kn3, exp_d[3]);
        hv[1] = hv[0]; ha[1] = ha[0];
        hv[0] = en;    ha[0] = a;
    endtask

    task automatic run_job(input logic [AW-1:0] base, input int ng,
                           input logic [NK-1:0] mask, input bit bad,
                           input bit spur);
        logic [AW-1:0] a;
        int d;
        i_base_addr  = base;
        i_num_groups = GW'(ng);
        i_kn_mask    = mask;
        i_start      = 1'b1;
        sample(1'b0, '0);
        chk("idle_busy", o_busy, 1'b0);
        step();
        i_start      = 1'b0;
        i_base_addr  = AW'($urandom);
        i_num_groups = GW'($urandom);
        i_kn_mask    = NK'($urandom);
        cur_mask     = mask;
        chk("err_clear", o_err, 1'b0);
        if (ng == 0) begin
            sample(1'b0, '0);
            chk("z_busy", o_busy, 1'b1);
            chk("z_done0", o_done, 1'b0);
            step();
            sample(1'b0, '0);
            chk("z_done1", o_done, 1'b1);
            chk("z_idle", o_busy, 1'b0);
            step();
            chk("z_done2", o_done, 1'b0);
            return;
        end
        for (int g = 0; g < ng; g++) begin
            for (int i = 0; i < NR; i++) begin
                a = base + AW'(NR * g + i);
                sample(1'b1, a);
                chk("fetch_busy", o_busy, 1'b1);
                if (spur && g == 0 && i == 0) i_start = 1'b1;
                if (bad && g == 0 && i == 1) i_data_req = 1'b1;
                step();
                i_start    = 1'b0;
                i_data_req = 1'b0;
            end
            d = $urandom_range(0, 2);
            for (int j = 0; j <= d; j++) begin
                sample(1'b0, '0);
                step();
            end
            sample(1'b0, '0);
            chk("wait_busy", o_busy, 1'b1);
            i_data_req = 1'b1;
            step();
            i_data_req = 1'b0;
        end
        sample(1'b0, '0);
        chk("done_early", o_done, 1'b0);
        chk("err_flag", o_err, bad);
        step();
        sample(1'b0, '0);
        chk("done_pulse", o_done, 1'b1);
        chk("done_idle", o_busy, 1'b0);
        step();
        chk("done_end", o_done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < NK; k++) salt[k] = 8'($urandom);
        model_reset();
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_en", o_mem_en, 1'b0);
        chk("rst_addr", o_mem_addr, '0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_err", o_err, 1'b0);
        sample(1'b0, '0);
        step();

        run_job(16'h0010, 1, 4'b1111, 1'b0, 1'b0);
        run_job(AW'($urandom), 2, 4'b0101, 1'b0, 1'b0);
        run_job(AW'($urandom), 0, 4'b1111, 1'b0, 1'b0);
        run_job(AW'($urandom), 2, NK'($urandom), 1'b1, 1'b1);
        run_job(AW'($urandom), 1, 4'b1010, 1'b0, 1'b0);
        run_job(16'hFFFE, 1, 4'b1111, 1'b0, 1'b0);

        // Reset during the second fetch cycle
        i_base_addr  = 16'h0200;
        i_num_groups = 16'd2;
        i_kn_mask    = 4'b1111;
        i_start      = 1'b1;
        step();
        i_start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_busy", o_busy, 1'b0);
        chk("mid_en", o_mem_en, 1'b0);
        chk("mid_addr", o_mem_addr, '0);
        chk("mid_err", o_err, 1'b0);
        model_reset();
        for (int c = 0; c < 4; c++) begin
            sample(1'b0, '0);
            step();
        end
        run_job(16'h0300, 2, 4'b1111, 1'b0, 1'b0);

        // Reset wins over a simultaneous start
        i_base_addr  = 16'h0400;
        i_num_groups = 16'd1;
        i_start      = 1'b1;
        rst          = 1'b1;
        step();
        rst     = 1'b0;
        i_start = 1'b0;
        chk("prio_busy", o_busy, 1'b0);
        model_reset();
        for (int c = 0; c < 3; c++) begin
            sample(1'b0, '0);
            step();
        end

        for (int n = 0; n < 8; n++) begin
            run_job(AW'($urandom), $urandom_range(0, 4), NK'($urandom),
                    1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
